// File: rtl/avalon_bus_arbiter_pkg.sv
// avalon_bus_arbiter_pkg: shared types and constants for the two-port Avalon-MM arbiter
package avalon_arb_pkg;
  typedef enum logic [1:0] {IDLE, GRANT, DONE} state_t;
  typedef logic port_t;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int TW = 16;
  localparam logic [DW-1:0] ABORT_DATA_DEFAULT = 32'hDEADBEEF;
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return v + 8'(v != 8'hFF);
  endfunction
endpackage

// File: rtl/avalon_bus_arbiter_if.sv
// avalon_bus_arbiter_if: one Avalon-MM link; master modport issues requests, slave modport answers
interface avalon_bus_arbiter_if;
  import avalon_arb_pkg::*;
  logic [AW-1:0] address;
  logic          read;
  logic          write;
  logic [DW-1:0] writedata;
  logic [DW-1:0] readdata;
  logic          waitrequest;
  modport master (output address, read, write, writedata, input readdata, waitrequest);
  modport slave (input address, read, write, writedata, output readdata, waitrequest);
endinterface

// File: rtl/avalon_bus_arbiter_rr_arbiter_2.sv
// rr_arbiter_2: combinational two-way round-robin pick; favours the port that did not win last
module rr_arbiter_2
  import avalon_arb_pkg::*;
(
  input  logic [1:0] req,
  input  port_t      last_grant,
  input  logic       enable,
  output port_t      grant,
  output logic       grant_valid
);
  always_comb begin
    grant_valid = enable && |req;
    grant = &req ? ~last_grant : req[1];
  end
endmodule

// File: rtl/avalon_bus_arbiter.sv
// avalon_bus_arbiter: serialises two Avalon-MM requesters onto one register slave with timeout abort
module avalon_bus_arbiter
  import avalon_arb_pkg::*;
#(
  parameter int unsigned   TIMEOUT_CYCLES = 255,
  parameter logic [DW-1:0] ABORT_DATA     = ABORT_DATA_DEFAULT
) (
  input  logic                 clock,
  input  logic                 reset,
  avalon_bus_arbiter_if.slave  avalon_slave0,
  avalon_bus_arbiter_if.slave  avalon_slave1,
  avalon_bus_arbiter_if.master avalon_master,
  output logic                 timeout_error,
  output logic [7:0]           timeout_count
);
  localparam logic [TW-1:0] LAST_WAIT = TW'(TIMEOUT_CYCLES - 1);
  state_t        state;
  port_t         last_grant, grant_q, grant;
  logic          grant_valid, wr_q, abort;
  logic [1:0]    req;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q, rdata0, rdata1, cap;
  logic [TW-1:0] wait_cnt;
  always_comb begin
    req = {avalon_slave1.read | avalon_slave1.write, avalon_slave0.read | avalon_slave0.write};
    abort = avalon_master.waitrequest && wait_cnt == LAST_WAIT;
    cap = avalon_master.waitrequest ? ABORT_DATA : avalon_master.readdata;
  end
  rr_arbiter_2 u_rr (
    .req         (req),
    .last_grant  (last_grant),
    .enable      (state == IDLE),
    .grant       (grant),
    .grant_valid (grant_valid)
  );
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      last_grant    <= 1'b1;
      grant_q       <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      wr_q          <= 1'b0;
      wait_cnt      <= '0;
      rdata0        <= '0;
      rdata1        <= '0;
      timeout_error <= 1'b0;
      timeout_count <= '0;
    end else begin
      case (state)
        IDLE: if (grant_valid) begin
          state      <= GRANT;
          grant_q    <= grant;
          last_grant <= grant;
          addr_q     <= grant ? avalon_slave1.address : avalon_slave0.address;
          wdata_q    <= grant ? avalon_slave1.writedata : avalon_slave0.writedata;
          wr_q       <= grant ? avalon_slave1.write : avalon_slave0.write;
          wait_cnt   <= '0;
        end
        GRANT: if (!avalon_master.waitrequest || abort) begin
          state <= DONE;
          if (!wr_q && grant_q) rdata1 <= cap;
          if (!wr_q && !grant_q) rdata0 <= cap;
          if (abort) begin
            timeout_error <= 1'b1;
            timeout_count <= sat_inc8(timeout_count);
          end
        end else wait_cnt <= wait_cnt + 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
  // Strobes and port handshakes are pure decodes of registered state
  assign avalon_master.address     = addr_q;
  assign avalon_master.writedata   = wdata_q;
  assign avalon_master.read        = state == GRANT && !wr_q;
  assign avalon_master.write       = state == GRANT && wr_q;
  assign avalon_slave0.waitrequest = !(state == DONE && !grant_q);
  assign avalon_slave1.waitrequest = !(state == DONE && grant_q);
  assign avalon_slave0.readdata    = rdata0;
  assign avalon_slave1.readdata    = rdata1;
endmodule

// File: tb/tb_avalon_bus_arbiter.sv
// tb_avalon_bus_arbiter: directed vectors with a queue scoreboard checking every port completion
module tb_avalon_bus_arbiter;
  logic clock, reset;
  logic [7:0] timeout_count;
  logic timeout_error;
  avalon_bus_arbiter_if s0_if ();
  avalon_bus_arbiter_if s1_if ();
  avalon_bus_arbiter_if m_if ();
  avalon_bus_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clock         (clock),
    .reset         (reset),
    .avalon_slave0 (s0_if),
    .avalon_slave1 (s1_if),
    .avalon_master (m_if),
    .timeout_error (timeout_error),
    .timeout_count (timeout_count)
  );
  typedef struct {int port; logic chk_data; logic [31:0] data;} exp_t;
  exp_t sb[$];
  int n_cmp = 0, n_bad = 0;
  logic hang = 0;
  int stall_n = 0, scnt = 0, rd_cnt = 0, wr_cnt = 0;
  logic [15:0] last_wa = 0;
  logic [31:0] last_wd = 0;
  initial clock = 0;
  always #5 clock = ~clock;
  // Register slave model: stalls stall_n cycles per transfer (or forever when hung)
  always_comb begin
    m_if.waitrequest = (m_if.read | m_if.write) && (hang || scnt < stall_n);
    m_if.readdata = m_if.address == 16'h0200 ? 32'd20 : {16'hC0DE, m_if.address};
  end
  always @(posedge clock) begin
    scnt <= (m_if.read | m_if.write) ? scnt + 1 : 0;
    if (m_if.read) rd_cnt <= rd_cnt + 1;
    if (m_if.write && !m_if.waitrequest) begin
      wr_cnt  <= wr_cnt + 1;
      last_wa <= m_if.address;
      last_wd <= m_if.writedata;
    end
  end
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic logic wreq(input int p);
    return p != 0 ? s1_if.waitrequest : s0_if.waitrequest;
  endfunction
  function automatic logic [31:0] rdat(input int p);
    return p != 0 ? s1_if.readdata : s0_if.readdata;
  endfunction
  task automatic drive(input int p, input logic rd, input logic wr, input logic [15:0] a, input logic [31:0] wd);
    if (p == 0) begin
      s0_if.read = rd; s0_if.write = wr; s0_if.address = a; s0_if.writedata = wd;
    end else begin
      s1_if.read = rd; s1_if.write = wr; s1_if.address = a; s1_if.writedata = wd;
    end
  endtask
  task automatic expect_rsp(input int p, input logic is_rd, input logic [31:0] d);
    exp_t e;
    e.port = p; e.chk_data = is_rd; e.data = d;
    sb.push_back(e);
  endtask
  task automatic xfer(input int p, input logic rd, input logic wr, input logic [15:0] a,
                      input logic [31:0] wd, input logic [31:0] ed, output int cyc);
    expect_rsp(p, rd && !wr, ed);
    drive(p, rd, wr, a, wd);
    cyc = 0;
    do begin @(negedge clock); cyc++; end while (wreq(p) && cyc < 40);
    drive(p, 0, 0, 0, 0);
  endtask
  always @(negedge clock) begin
    for (int p = 0; p < 2; p++) begin
      if (wreq(p) === 1'b0) begin
        if (sb.size() == 0) chk("sb_unexpected_done", 64'(p), 64'hFF);
        else begin
          exp_t e;
          e = sb.pop_front();
          chk("sb_port", 64'(p), 64'(e.port));
          if (e.chk_data) chk("sb_readdata", 64'(rdat(p)), 64'(e.data));
        end
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end
  initial begin
    int cyc, n0, n1, rd_before;
    reset = 1;
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 0;
    chk("rst_wr0", 64'(s0_if.waitrequest), 1);
    chk("rst_wr1", 64'(s1_if.waitrequest), 1);
    chk("rst_rd0", 64'(s0_if.readdata), 0);
    chk("rst_rd1", 64'(s1_if.readdata), 0);
    chk("rst_mstrobe", 64'({m_if.read, m_if.write}), 0);
    chk("rst_maddr", 64'({m_if.address, m_if.writedata}), 0);
    chk("rst_terr", 64'({timeout_error, timeout_count}), 0);
    // Port 0 write, no slave stall
    expect_rsp(0, 0, 0);
    drive(0, 0, 1, 16'h0100, 32'h0000_00AA);
    @(negedge clock);
    chk("w_cyc1_strobe", 64'({m_if.write, m_if.read}), 64'b10);
    chk("w_cyc1_addr", 64'(m_if.address), 64'h0100);
    chk("w_cyc1_data", 64'(m_if.writedata), 64'hAA);
    chk("w_cyc1_wr0", 64'(s0_if.waitrequest), 1);
    @(negedge clock);
    chk("w_cyc2_wr0", 64'(s0_if.waitrequest), 0);
    chk("w_cyc2_mwrite", 64'(m_if.write), 0);
    drive(0, 0, 0, 0, 0);
    @(negedge clock);
    chk("w_cyc3_wr0", 64'(s0_if.waitrequest), 1);
    chk("w_slave_log", 64'({last_wa, last_wd}), 64'h0100_0000_00AA);
    // Port 1 read with one stall cycle
    stall_n = 1;
    xfer(1, 1, 0, 16'h0200, 0, 32'd20, cyc);
    chk("r1_cycles", 64'(cyc), 3);
    chk("r1_wr0_idle", 64'(s0_if.waitrequest), 1);
    @(negedge clock);
    // Both ports read continuously; grants must alternate starting with port 0
    stall_n = 0;
    for (int i = 0; i < 3; i++) begin
      expect_rsp(0, 1, 32'hC0DE_0300);
      expect_rsp(1, 1, 32'hC0DE_0400);
    end
    drive(0, 1, 0, 16'h0300, 0);
    drive(1, 1, 0, 16'h0400, 0);
    n0 = 0; n1 = 0; cyc = 0;
    while ((n0 < 3 || n1 < 3) && cyc < 60) begin
      @(negedge clock);
      cyc++;
      if (!s0_if.waitrequest && ++n0 == 3) drive(0, 0, 0, 0, 0);
      if (!s1_if.waitrequest && ++n1 == 3) drive(1, 0, 0, 0, 0);
    end
    chk("rr_cycles", 64'(cyc), 17);
    @(negedge clock);
    // Hung slave, abort after 4 stall cycles
    hang = 1;
    xfer(0, 1, 0, 16'h0500, 0, 32'hDEADBEEF, cyc);
    chk("to_cycles", 64'(cyc), 5);
    chk("to_error", 64'(timeout_error), 1);
    chk("to_count", 64'(timeout_count), 1);
    chk("to_mread", 64'(m_if.read), 0);
    @(negedge clock);
    // Reset during GRANT drops the transfer silently
    drive(1, 1, 0, 16'h0700, 0);
    @(negedge clock);
    chk("rst_mid_grant", 64'(m_if.read), 1);
    reset = 1;
    @(negedge clock);
    chk("rstm_mread", 64'({m_if.read, m_if.write}), 0);
    chk("rstm_wr", 64'({s0_if.waitrequest, s1_if.waitrequest}), 64'b11);
    chk("rstm_count", 64'(timeout_count), 0);
    chk("rstm_error", 64'(timeout_error), 0);
    chk("rstm_rd1", 64'(s1_if.readdata), 0);
    reset = 0;
    hang = 0;
    stall_n = 1;
    drive(1, 0, 0, 0, 0);
    @(negedge clock);
    xfer(1, 1, 0, 16'h0200, 0, 32'd20, cyc);
    chk("post_rst_cycles", 64'(cyc), 3);
    @(negedge clock);
    // Read and write together resolve to a write
    stall_n = 0;
    rd_before = rd_cnt;
    xfer(0, 1, 1, 16'h0600, 32'h5, 0, cyc);
    chk("rw_cycles", 64'(cyc), 2);
    @(negedge clock);
    chk("rw_no_read", 64'(rd_cnt - rd_before), 0);
    chk("rw_slave_log", 64'({last_wa, last_wd}), 64'h0600_0000_0005);
    chk("rw_rd0_hold", 64'(s0_if.readdata), 0);
    repeat (3) @(negedge clock);
    chk("sb_drain", 64'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/avalon_bus_arbiter.md
# avalon_bus_arbiter

Two-master to one-slave Avalon-MM arbiter in front of the ID-switch/loopback register slave. Lets the ESP32 SPI bridge (port 0) and the soft-CPU data master (port 1) share the 16-bit-address register slave with fair round-robin access. Serialises transfers, returns read data to the granted master and aborts hung transfers with a timeout.

## Interface
- TIMEOUT_CYCLES, 255: downstream waitrequest-high cycles before an abort (1..65535).
- ABORT_DATA, 32'hDEADBEEF: readdata returned on an aborted read.

- clock  in  1  sole clock
- reset  in  1  synchronous, active-high
- avalon_slave0_address / avalon_slave1_address  in  16  requester address
- avalon_slave0_read / avalon_slave1_read  in  1  read request
- avalon_slave0_write / avalon_slave1_write  in  1  write request
- avalon_slave0_writedata / avalon_slave1_writedata  in  32  write data
- avalon_slave0_readdata / avalon_slave1_readdata  out  32  read data, valid while that port's waitrequest is low
- avalon_slave0_waitrequest / avalon_slave1_waitrequest  out  1  stall to requester
- avalon_master_address  out  16  to register slave
- avalon_master_read / avalon_master_write  out  1  downstream strobes
- avalon_master_writedata  out  32
- avalon_master_readdata  in  32
- avalon_master_waitrequest  in  1  combinational stall from slave
- timeout_error  out  1  sticky, set on any abort
- timeout_count  out  8  saturating abort counter

## Operation
- FSM states: IDLE, GRANT, DONE.
- A port requests when read or write is high. If both are high, the transfer is a write.
- IDLE, with no request: stay.
- IDLE, with a request: latch grant, address, writedata and direction into registers, then go to GRANT.
- Arbitration is round-robin. With both ports requesting, grant the port that is not last_grant. With one port requesting, grant that port. last_grant updates on every grant.
- GRANT: drive avalon_master_* from the latched registers.
  - If avalon_master_waitrequest is low: capture avalon_master_readdata (reads only) and go to DONE.
  - If it is high: increment wait_cnt. When wait_cnt reaches TIMEOUT_CYCLES, abort. The abort loads ABORT_DATA as read data, sets timeout_error, increments timeout_count (saturating at 255) and goes to DONE.
- DONE: the granted port's waitrequest is low for exactly one cycle and its readdata holds the captured value. Next state is IDLE.
- The requester must drop or change its request after the waitrequest-low cycle. A request still held in IDLE is treated as a new transfer.
- Port waitrequest is high in every state except DONE for that port. A non-granted port stays stalled throughout.
- Port readdata registers update only when entering DONE for that port. Otherwise they hold their value.
- Downstream read and write are never asserted outside GRANT. Downstream signals are stable for the whole of GRANT.

## Timing
- All outputs are registered or decoded from registered state. There is no combinational path from a requester input to any output.
- Reset values:
  - state IDLE, last_grant=1 (so port 0 wins the first tie).
  - both waitrequest=1, both readdata=0.
  - master read/write=0, master address/writedata=0.
  - timeout_error=0, timeout_count=0, wait_cnt=0.
- Request sampled at edge 0: GRANT during cycle 1, DONE during cycle 1+N+1, where N is the number of downstream wait cycles.
  - Write to the register slave (N=0): port waitrequest low in cycle 2.
  - Read (slave stalls one cycle, N=1): port waitrequest low in cycle 3.
- Back-to-back transfers from alternating ports need 3 cycles minimum per write.
- Abort: DONE follows the GRANT cycle in which wait_cnt reaches TIMEOUT_CYCLES. Master strobes are deasserted in the DONE cycle.
- Reset asserted mid-transfer: on the next edge, FSM to IDLE, master strobes low, counters and flags cleared. The transfer in flight is dropped with no response.

## Structure
- Shared package avalon_arb_pkg holds:
  - state enum {IDLE, GRANT, DONE}
  - port-index type (1 bit)
  - default ABORT_DATA constant
  - TIMEOUT counter width (16)
- Sub-module rr_arbiter_2 handles arbitration:
  - inputs req[1:0], last_grant, enable
  - outputs grant index and grant_valid
  - it is purely combinational; last_grant is registered in the top FSM.

## Test plan
- Port 0 write addr 16'h0100 data 32'h0000_00AA, slave waitrequest never high -> master write seen in cycle 1 with those values; port0 waitrequest low in cycle 2 only.
- Port 1 read addr 16'h0200, slave stalls 1 cycle then returns 32'd20 -> port1 waitrequest low in cycle 3 with readdata=32'd20; port0 waitrequest stays 1.
- Both ports request reads together, held for 3 transactions each -> grants alternate 0,1,0,1,0,1 and no port waits more than one foreign transfer.
- Slave holds waitrequest high forever, TIMEOUT_CYCLES=4, read from port 0 -> DONE after 4 stall cycles, readdata=32'hDEADBEEF, timeout_error=1, timeout_count=1, master read low.
- Reset pulsed during GRANT of port 1's read -> next cycle state IDLE, master read=0, both waitrequests=1, timeout_count=0; a following port 1 read completes normally.
- Port 0 asserts read and write together with writedata 32'h5 -> downstream write only, no read strobe ever.
